// File: rtl/par_check.sv
// rtl/par_check.sv - registered even/odd parity flags for one received word
// One XOR tree feeds both flags so they stay mutually exclusive outside reset.
module par_check #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic             even,
  output logic             odd
);

  logic p;

  assign p = ^in;

  // Both flags clear in reset, so (0,0) marks "no word checked yet".
  always_ff @(posedge clk) begin
    if (rst) begin
      even <= 1'b0;
      odd  <= 1'b0;
    end else begin
      even <= ~p;
      odd  <= p;
    end
  end

endmodule

// File: tb/tb_par_check.sv
// tb/tb_par_check.sv - table-driven and random checks for par_check
// Directed vectors apply one word per edge; results are sampled 1 time unit after the edge.
module tb_par_check;

  typedef struct {
    logic        r;
    logic [8:0]  w;
    logic        ee;
    logic        eo;
    string       name;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [8:0]  in9;
  logic [15:0] in16;
  logic        even9, odd9, even16, odd16;

  int pass_cnt;
  int total_cnt;

  vec_t vecs [17];

  par_check #(.WIDTH(9)) dut9 (
    .clk  (clk),
    .rst  (rst),
    .in   (in9),
    .even (even9),
    .odd  (odd9)
  );

  par_check #(.WIDTH(16)) dut16 (
    .clk  (clk),
    .rst  (rst),
    .in   (in16),
    .even (even16),
    .odd  (odd16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference parity by counting ones, independent of the reduction operator.
  function automatic logic ones_odd(input logic [63:0] v, input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) c += int'(v[i]);
    return c[0];
  endfunction

  task automatic step(input logic r, input logic [8:0] a, input logic [15:0] b);
    rst  = r;
    in9  = a;
    in16 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic ge, input logic go,
                       input logic we, input logic wo);
    total_cnt++;
    if (ge === we && go === wo) pass_cnt++;
    else $display("FAIL %s: got even=%b odd=%b, want even=%b odd=%b",
                  name, ge, go, we, wo);
  endtask

  initial begin
    logic [8:0]  w;
    logic        exp_p;
    logic        gate_ok;

    pass_cnt  = 0;
    total_cnt = 0;
    rst  = 1'b1;
    in9  = 9'h000;
    in16 = 16'h0000;

    vecs[0]  = '{1'b1, 9'h0AB, 1'b0, 1'b0, "reset_edge1"};
    vecs[1]  = '{1'b1, 9'h1FF, 1'b0, 1'b0, "reset_edge2"};
    vecs[2]  = '{1'b0, 9'b101010111, 1'b1, 1'b0, "dir_6ones"};
    vecs[3]  = '{1'b0, 9'b101110111, 1'b0, 1'b1, "dir_7ones_a"};
    vecs[4]  = '{1'b0, 9'b100000111, 1'b1, 1'b0, "dir_4ones"};
    vecs[5]  = '{1'b0, 9'b101111011, 1'b0, 1'b1, "dir_7ones_b"};
    vecs[6]  = '{1'b0, 9'b110000111, 1'b0, 1'b1, "dir_5ones"};
    vecs[7]  = '{1'b0, 9'h000, 1'b1, 1'b0, "bnd_zero"};
    vecs[8]  = '{1'b0, 9'h1FF, 1'b0, 1'b1, "bnd_all_ones"};
    vecs[9]  = '{1'b0, 9'h001, 1'b0, 1'b1, "bnd_lsb"};
    vecs[10] = '{1'b0, 9'h100, 1'b0, 1'b1, "bnd_msb"};
    vecs[11] = '{1'b0, 9'h003, 1'b1, 1'b0, "pre_mid_even"};
    vecs[12] = '{1'b0, 9'h1FF, 1'b0, 1'b1, "mid_odd"};
    vecs[13] = '{1'b1, 9'h000, 1'b0, 1'b0, "mid_reset"};
    vecs[14] = '{1'b0, 9'h003, 1'b1, 1'b0, "mid_after_even"};
    vecs[15] = '{1'b0, 9'h007, 1'b0, 1'b1, "mid_after_odd"};
    vecs[16] = '{1'b0, 9'h080, 1'b0, 1'b1, "bit7_only"};

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].r, vecs[i].w, 16'h0000);
      check(vecs[i].name, even9, odd9, vecs[i].ee, vecs[i].eo);
    end

    // Reset dominates a same-cycle word change on the wider instance too.
    step(1'b1, 9'h1FF, 16'hFFFE);
    check("w16_reset", even16, odd16, 1'b0, 1'b0);
    step(1'b0, 9'h000, 16'h8001);
    check("w16_8001", even16, odd16, 1'b1, 1'b0);
    step(1'b0, 9'h000, 16'h8000);
    check("w16_8000", even16, odd16, 1'b0, 1'b1);
    step(1'b0, 9'h000, 16'h0001);
    check("w16_0001", even16, odd16, 1'b0, 1'b1);

    // Random stream: each result must match the word sampled on the previous edge.
    for (int n = 0; n < 1000; n++) begin
      w = 9'($urandom_range(0, 511));
      step(1'b0, w, 16'($urandom_range(0, 65535)));
      exp_p = ones_odd({55'd0, w}, 9);
      check("rand_word", even9, odd9, ~exp_p, exp_p);
      gate_ok = even9 ^ odd9;
      check("rand_exclusive", gate_ok, 1'b0, 1'b1, 1'b0);
      exp_p = ones_odd({48'd0, in16}, 16);
      check("rand_w16", even16, odd16, ~exp_p, exp_p);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
